// File: rtl/regread_stage_pkg.sv
// Shared types for the register-read stage: beat tag, burst FSM states, beat width.
package regread_stage_pkg;

  localparam int WIDTH_BEAT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  typedef struct packed {
    logic                  slice;
    logic                  first;
    logic                  last;
    logic                  masked;
    logic [WIDTH_BEAT-1:0] beat;
  } rr_tag_t;

  function automatic logic [WIDTH_BEAT-1:0] beat_sat_inc(input logic [WIDTH_BEAT-1:0] b);
    return (&b) ? b : b + {{(WIDTH_BEAT-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/regread_stage_if.sv
// Downstream operand bus of the register-read stage (valid/stall handshake plus beat tags).
interface regread_stage_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_BEAT = regread_stage_pkg::WIDTH_BEAT
);
  logic                  O_Valid;
  logic [WIDTH_DATA-1:0] O_Data;
  logic                  O_Slice;
  logic                  O_First;
  logic                  O_Last;
  logic [WIDTH_BEAT-1:0] O_Beat;
  logic                  I_Stall;

  modport master (
    output O_Valid, O_Data, O_Slice, O_First, O_Last, O_Beat,
    input  I_Stall
  );

  modport slave (
    input  O_Valid, O_Data, O_Slice, O_First, O_Last, O_Beat,
    output I_Stall
  );
endinterface

// File: rtl/regread_fifo.sv
// Generic synchronous FIFO (power-of-two depth) with occupancy count and full/empty flags.
module regread_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Entry storage; an empty slot's contents are never observed downstream.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/regread_stage_chk.sv
// Simulation checks for the register-read stage: credit overflow and slice protocol.
module regread_stage_chk (
  input logic clock,
  input logic reset,
  input logic push_i,
  input logic full_i,
  input logic proto_err_i
);
  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push_i && full_i))
    else $error("regread_stage: push into full skid FIFO");

  a_slice_proto: assert property (@(posedge clock) disable iff (reset) !proto_err_i)
    else $error("regread_stage: scalar beat accepted inside slice burst");
endmodule

// File: rtl/regread_stage.sv
// Register-read stage: issues RF reads for index beats, captures 1-cycle-latency data into a
// credit-controlled skid FIFO and tags slice bursts with first/last/beat number.
module regread_stage
  import regread_stage_pkg::*;
#(
  parameter int WIDTH_INDEX = 7,
  parameter int WIDTH_DATA  = 32,
  parameter int DEPTH_BUF   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Req,
  input  logic                   I_Slice,
  input  logic                   I_Last,
  input  logic                   I_Masked,
  input  logic [WIDTH_INDEX-1:0] I_Index,
  output logic                   O_Stall,
  output logic                   O_RF_Req,
  output logic [WIDTH_INDEX-1:0] O_RF_Index,
  input  logic [WIDTH_DATA-1:0]  I_RF_Data,
  regread_stage_if.master        ds
);
  localparam int WIDTH_CNT  = $clog2(DEPTH_BUF) + 1;
  localparam int WIDTH_FIFO = WIDTH_DATA + $bits(rr_tag_t);

  typedef struct packed {
    logic    valid;
    rr_tag_t tag;
  } preg_t;

  preg_t                  p_q, p_d;
  burst_state_e           state_q, state_d;
  logic [WIDTH_BEAT-1:0]  beat_q, beat_d;
  rr_tag_t                tag_s;
  logic                   accept_s;
  logic                   proto_err_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   valid_s;
  logic [WIDTH_DATA-1:0]  push_data_s;
  logic [WIDTH_DATA-1:0]  head_data_s;
  rr_tag_t                head_tag_s;
  logic [WIDTH_FIFO-1:0]  fifo_out_s;
  logic [WIDTH_CNT-1:0]   fifo_count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [WIDTH_CNT:0]     credit_s;

  // Stored entries plus the read in flight must never exceed the FIFO depth.
  assign credit_s   = {1'b0, fifo_count_s} + {{WIDTH_CNT{1'b0}}, p_q.valid};
  assign O_Stall    = (credit_s >= (WIDTH_CNT+1)'(DEPTH_BUF));
  assign accept_s   = I_Req & ~O_Stall & ~reset;
  assign O_RF_Req   = accept_s & ~I_Masked;
  assign O_RF_Index = I_Index;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Burst sequencing; beat_q holds the beat number of the last accepted burst beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    proto_err_s = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          beat_d = '0;
          if (I_Slice && !I_Last) begin
            state_d = ST_BURST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (!I_Slice) begin
            proto_err_s = 1'b1;
            state_d     = ST_IDLE;
            beat_d      = '0;
          end else if (I_Last) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            state_d = ST_BURST;
            beat_d  = beat_sat_inc(beat_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      beat_d  = beat_q;
    end
  end

  always_comb begin
    tag_s        = '0;
    tag_s.masked = I_Masked;
    case (state_q)
      ST_IDLE: begin
        if (I_Slice) begin
          tag_s.slice = 1'b1;
          tag_s.first = 1'b1;
          tag_s.last  = I_Last;
        end else begin
          tag_s.slice = 1'b0;
        end
      end
      ST_BURST: begin
        if (I_Slice) begin
          tag_s.slice = 1'b1;
          tag_s.last  = I_Last;
          tag_s.beat  = beat_sat_inc(beat_q);
        end else begin
          tag_s.slice = 1'b0;
        end
      end
      default: tag_s.slice = 1'b0;
    endcase
  end

  always_comb begin
    p_d       = '0;
    p_d.valid = accept_s;
    p_d.tag   = tag_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign push_s      = p_q.valid;
  assign push_data_s = p_q.tag.masked ? '0 : I_RF_Data;
  assign valid_s     = ~fifo_empty_s;
  assign pop_s       = valid_s & ~ds.I_Stall;

  regread_fifo #(
    .WIDTH (WIDTH_FIFO),
    .DEPTH (DEPTH_BUF)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .data_i  ({push_data_s, p_q.tag}),
    .pop_i   (pop_s),
    .data_o  (fifo_out_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign {head_data_s, head_tag_s} = fifo_out_s;

  // Outputs read as zero whenever no entry is presented.
  assign ds.O_Valid = valid_s;
  assign ds.O_Data  = (valid_s & ~head_tag_s.masked) ? head_data_s : '0;
  assign ds.O_Slice = valid_s & head_tag_s.slice;
  assign ds.O_First = valid_s & head_tag_s.first;
  assign ds.O_Last  = valid_s & head_tag_s.last;
  assign ds.O_Beat  = valid_s ? head_tag_s.beat : '0;

  regread_stage_chk u_chk (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_s),
    .full_i      (fifo_full_s),
    .proto_err_i (proto_err_s)
  );
endmodule

// File: tb/tb_regread_stage.sv
// Self-checking bench for regread_stage: directed scenarios plus random traffic against a
// queue-based transaction model of the stage.
module tb_regread_stage;
  localparam int WI    = 7;
  localparam int WD    = 32;
  localparam int WB    = 8;
  localparam int DEPTH = 2;

  typedef struct {
    logic [WD-1:0] data;
    bit            slice;
    bit            first;
    bit            last;
    int            beat;
    bit            pushed;
  } item_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Req, I_Slice, I_Last, I_Masked;
  logic [WI-1:0] I_Index;
  logic          O_Stall, O_RF_Req;
  logic [WI-1:0] O_RF_Index;
  logic [WD-1:0] I_RF_Data;

  regread_stage_if #(.WIDTH_DATA(WD), .WIDTH_BEAT(WB)) ds ();

  regread_stage #(.WIDTH_INDEX(WI), .WIDTH_DATA(WD), .DEPTH_BUF(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Req      (I_Req),
    .I_Slice    (I_Slice),
    .I_Last     (I_Last),
    .I_Masked   (I_Masked),
    .I_Index    (I_Index),
    .O_Stall    (O_Stall),
    .O_RF_Req   (O_RF_Req),
    .O_RF_Index (O_RF_Index),
    .I_RF_Data  (I_RF_Data),
    .ds         (ds)
  );

  always #5 clock = ~clock;

  // Reference model state: items accepted but not yet consumed, in order.
  item_t         q[$];
  logic [WD-1:0] rf [128];
  bit            m_burst;
  int            m_beat;
  bit            prev_rf_req;
  logic [WI-1:0] prev_idx;
  bit            last_acc;
  int            passed;
  int            total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock of stimulus; called just after a rising edge, returns just after the next one.
  task automatic step(input bit req, input bit slice, input bit last, input bit masked,
                      input logic [WI-1:0] idx, input bit stall);
    bit    exp_stall, acc, exp_rfreq, exp_valid;
    item_t it;
    I_Req      = req;
    I_Slice    = slice;
    I_Last     = last;
    I_Masked   = masked;
    I_Index    = idx;
    ds.I_Stall = stall;
    I_RF_Data  = prev_rf_req ? rf[prev_idx] : $urandom;
    @(negedge clock);
    exp_stall = (q.size() >= DEPTH);
    acc       = req && !exp_stall;
    exp_rfreq = acc && !masked;
    check("o_stall", O_Stall, exp_stall);
    check("o_rf_req", O_RF_Req, exp_rfreq);
    if (exp_rfreq) check("o_rf_index", O_RF_Index, idx);
    exp_valid = 1'b0;
    if (q.size() != 0) exp_valid = q[0].pushed;
    check("o_valid", ds.O_Valid, exp_valid);
    if (exp_valid) begin
      check("o_data", ds.O_Data, q[0].data);
      check("o_slice", ds.O_Slice, q[0].slice);
      check("o_first", ds.O_First, q[0].first);
      check("o_last", ds.O_Last, q[0].last);
      check("o_beat", ds.O_Beat, q[0].beat);
    end
    if (acc) begin
      it.data   = masked ? '0 : rf[idx];
      it.pushed = 1'b0;
      it.slice  = 1'b0;
      it.first  = 1'b0;
      it.last   = 1'b0;
      it.beat   = 0;
      if (!slice) begin
        m_burst = 1'b0;
        m_beat  = 0;
      end else if (!m_burst) begin
        it.slice = 1'b1;
        it.first = 1'b1;
        it.last  = last;
        m_beat   = 0;
        m_burst  = !last;
      end else begin
        m_beat   = (m_beat < 255) ? m_beat + 1 : 255;
        it.slice = 1'b1;
        it.last  = last;
        it.beat  = m_beat;
        m_burst  = !last;
      end
    end
    @(posedge clock);
    #1;
    if (exp_valid && !stall) void'(q.pop_front());
    foreach (q[i]) q[i].pushed = 1'b1;
    if (acc) q.push_back(it);
    prev_rf_req = exp_rfreq;
    prev_idx    = idx;
    last_acc    = acc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    I_Req     = 1'b0;
    I_RF_Data = prev_rf_req ? rf[prev_idx] : $urandom;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    q.delete();
    m_burst     = 1'b0;
    m_beat      = 0;
    prev_rf_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    I_Req      = 1'b0;
    ds.I_Stall = 1'b0;
    I_RF_Data  = $urandom;
    @(negedge clock);
    check("rst_valid", ds.O_Valid, 1'b0);
    check("rst_stall", O_Stall, 1'b0);
    check("rst_rf_req", O_RF_Req, 1'b0);
    check("rst_data", ds.O_Data, '0);
    check("rst_slice", ds.O_Slice, 1'b0);
    check("rst_first", ds.O_First, 1'b0);
    check("rst_last", ds.O_Last, 1'b0);
    check("rst_beat", ds.O_Beat, '0);
    @(posedge clock);
    #1;
    prev_rf_req = 1'b0;
  endtask

  initial begin
    int sent;
    passed = 0;
    total  = 0;
    for (int i = 0; i < 128; i++) rf[i] = $urandom;
    rf[5] = 32'hDEAD_BEEF;
    reset      = 1'b1;
    I_Req      = 1'b0;
    I_Slice    = 1'b0;
    I_Last     = 1'b0;
    I_Masked   = 1'b0;
    I_Index    = '0;
    I_RF_Data  = '0;
    ds.I_Stall = 1'b0;
    m_burst    = 1'b0;
    m_beat     = 0;
    prev_rf_req = 1'b0;
    prev_idx   = '0;
    last_acc   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_outputs();

    // Scalar read of index 5.
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd5, 1'b0);
    idle(3);

    // Four-beat slice over indices 8..11.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 3), 1'b0, 7'(8 + i), 1'b0);
    idle(4);

    // Slice with beat 1 masked.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 3), (i == 1), 7'(20 + i), 1'b0);
    idle(4);

    // Continuous requests against a 5-cycle downstream stall.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 7'(60 + i), (i < 5));
    idle(4);

    // Single-beat slice.
    step(1'b1, 1'b1, 1'b1, 1'b0, 7'd30, 1'b0);
    idle(3);

    // Reset in the middle of a stalled burst with the FIFO full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 7'(40 + i), 1'b1);
    do_reset();
    check_reset_outputs();
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd50, 1'b0);
    idle(3);

    // Long burst: beat number must stop at 255.
    sent = 0;
    for (int k = 0; k < 2000 && sent < 300; k++) begin
      step(1'b1, 1'b1, (sent == 299), 1'b0, 7'($urandom_range(0, 127)), 1'b0);
      if (last_acc) sent++;
    end
    check("long_burst_done", sent, 300);
    idle(3);

    // Random legal traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 3) != 0),
           m_burst ? 1'b1 : 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           7'($urandom_range(0, 127)),
           ($urandom_range(0, 2) == 0));
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
